// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, forwarding selects and stage control bundles.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_IM  = 2'b01;
  localparam logic [1:0] FWD_IW  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned TMO_W = 8;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ix;
    logic ix_im;
    logic im_iw;
  } stage_en_t;

  typedef struct packed {
    logic if_id;
    logic id_ix;
    logic ix_im;
    logic im_iw;
  } stage_flush_t;

  localparam stage_en_t    EN_ALL   = '1;
  localparam stage_flush_t FL_NONE  = '0;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one IX source register.
// Ports: src, im/iw dest + write flags in; sel out (00 reg, 01 IM, 10 IW).
module fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] im_dest_reg,
  input  logic       im_write_to_reg,
  input  logic [4:0] iw_dest_reg,
  input  logic       iw_write_to_reg,
  output logic [1:0] sel
);

  logic im_hit;
  logic iw_hit;

  assign im_hit = im_write_to_reg
                & (im_dest_reg != REG_ZERO)
                & (im_dest_reg == src);

  assign iw_hit = iw_write_to_reg
                & (iw_dest_reg != REG_ZERO)
                & (iw_dest_reg == src);

  // IM holds the younger result, so it wins over IW.
  always_comb begin
    sel = FWD_REG;
    unique case (1'b1)
      im_hit:            sel = FWD_IM;
      (iw_hit & ~im_hit): sel = FWD_IW;
      default:           sel = FWD_REG;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the IF/ID/IX/IM/IW pipeline.
// Ports: hazard inputs from ID/IX/IM/IW + dmem; enables, flushes, fwd sels, stats out.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ix_rs,
  input  logic [4:0]       ix_rt,
  input  logic [4:0]       ix_dest_reg,
  input  logic             ix_write_to_reg,
  input  logic             ix_is_load,
  input  logic             ix_update_pc,
  input  logic [4:0]       im_dest_reg,
  input  logic [4:0]       iw_dest_reg,
  input  logic             im_write_to_reg,
  input  logic             iw_write_to_reg,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ix_en,
  output logic             ix_im_en,
  output logic             im_iw_en,
  output logic             if_id_flush,
  output logic             id_ix_flush,
  output logic             ix_im_flush,
  output logic             im_iw_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_err
);

  state_e           state_q;
  state_e           state_d;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;

  logic             wait_req;
  logic             tmo_hit;
  logic             mem_stall;
  logic             lu_match;
  logic             branch;
  logic             load_use;

  stage_en_t        en;
  stage_flush_t     fl;

  logic [1:0]       fa_raw;
  logic [1:0]       fb_raw;

  // A timeout turns the would-be wait cycle into a normal advance.
  assign wait_req  = dmem_req & ~dmem_ready;
  assign tmo_hit   = wait_req
                   & (tmo_q == TMO_W'(MEM_TIMEOUT));
  assign mem_stall = wait_req & ~tmo_hit;

  assign lu_match = ix_is_load
                  & ix_write_to_reg
                  & (ix_dest_reg != REG_ZERO)
                  & ((id_uses_rs & (id_rs == ix_dest_reg))
                   | (id_uses_rt & (id_rt == ix_dest_reg)));

  // A taken branch squashes the dependent ID instruction,
  // so a coincident load-use needs no stall.
  assign branch   = ix_update_pc & ~mem_stall;
  assign load_use = lu_match & ~mem_stall & ~ix_update_pc;

  always_comb begin
    en = EN_ALL;
    fl = FL_NONE;
    unique case (1'b1)
      ~rst_n: begin
        en    = EN_ALL;
        en.pc = 1'b0;
        fl    = '1;
      end
      (rst_n & mem_stall): begin
        en       = '0;
        en.im_iw = 1'b1;
        fl.im_iw = 1'b1;
      end
      (rst_n & branch): begin
        fl.if_id = 1'b1;
        fl.id_ix = 1'b1;
      end
      (rst_n & load_use): begin
        en.pc    = 1'b0;
        en.if_id = 1'b0;
        fl.id_ix = 1'b1;
      end
      default: begin
        en = EN_ALL;
        fl = FL_NONE;
      end
    endcase
  end

  assign pc_en       = en.pc;
  assign if_id_en    = en.if_id;
  assign id_ix_en    = en.id_ix;
  assign ix_im_en    = en.ix_im;
  assign im_iw_en    = en.im_iw;
  assign if_id_flush = fl.if_id;
  assign id_ix_flush = fl.id_ix;
  assign ix_im_flush = fl.ix_im;
  assign im_iw_flush = fl.im_iw;

  fwd_unit u_fwd_a (
    .src             (ix_rs),
    .im_dest_reg     (im_dest_reg),
    .im_write_to_reg (im_write_to_reg),
    .iw_dest_reg     (iw_dest_reg),
    .iw_write_to_reg (iw_write_to_reg),
    .sel             (fa_raw)
  );

  fwd_unit u_fwd_b (
    .src             (ix_rt),
    .im_dest_reg     (im_dest_reg),
    .im_write_to_reg (im_write_to_reg),
    .iw_dest_reg     (iw_dest_reg),
    .iw_write_to_reg (iw_write_to_reg),
    .sel             (fb_raw)
  );

  assign fwd_a_sel = rst_n ? fa_raw : FWD_REG;
  assign fwd_b_sel = rst_n ? fb_raw : FWD_REG;

  // First wait cycle out of RUN restarts the timeout count.
  always_comb begin
    state_d = RUN;
    tmo_d   = '0;
    if (mem_stall) begin
      state_d = MEM_WAIT;
      tmo_d   = (state_q == RUN) ? TMO_W'(1)
                                 : tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
      mem_err      <= 1'b0;
    end else begin
      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (branch && (flush_events != '1))
        flush_events <= flush_events + 1'b1;
      if (tmo_hit)
        mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4.
// Stimulus pushes hand-computed expectations; a monitor pops at negedge.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic [4:0]  ix_rs, ix_rt, ix_dest_reg;
  logic        ix_write_to_reg, ix_is_load;
  logic        ix_update_pc;
  logic [4:0]  im_dest_reg, iw_dest_reg;
  logic        im_write_to_reg, iw_write_to_reg;
  logic        dmem_req, dmem_ready;
  logic        pc_en, if_id_en, id_ix_en;
  logic        ix_im_en, im_iw_en;
  logic        if_id_flush, id_ix_flush;
  logic        ix_im_flush, im_iw_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cycles, flush_events;
  logic        mem_err;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ix_rs           (ix_rs),
    .ix_rt           (ix_rt),
    .ix_dest_reg     (ix_dest_reg),
    .ix_write_to_reg (ix_write_to_reg),
    .ix_is_load      (ix_is_load),
    .ix_update_pc    (ix_update_pc),
    .im_dest_reg     (im_dest_reg),
    .iw_dest_reg     (iw_dest_reg),
    .im_write_to_reg (im_write_to_reg),
    .iw_write_to_reg (iw_write_to_reg),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ix_en        (id_ix_en),
    .ix_im_en        (ix_im_en),
    .im_iw_en        (im_iw_en),
    .if_id_flush     (if_id_flush),
    .id_ix_flush     (id_ix_flush),
    .ix_im_flush     (ix_im_flush),
    .im_iw_flush     (im_iw_flush),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .mem_err         (mem_err)
  );

  typedef struct {
    string      nm;
    logic [4:0] en;
    logic [3:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    int         st;
    int         fe;
    logic       er;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr();
    id_rs = '0; id_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0;
    ix_rs = '0; ix_rt = '0; ix_dest_reg = '0;
    ix_write_to_reg = 0; ix_is_load = 0;
    ix_update_pc = 0;
    im_dest_reg = '0; iw_dest_reg = '0;
    im_write_to_reg = 0; iw_write_to_reg = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic ex(input string nm,
                    input logic [4:0] en,
                    input logic [3:0] fl,
                    input logic [1:0] fa,
                    input logic [1:0] fb,
                    input int st, input int fe,
                    input logic er);
    exp_t e;
    e.nm = nm; e.en = en; e.fl = fl;
    e.fa = fa; e.fb = fb;
    e.st = st; e.fe = fe; e.er = er;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [4:0] g_en;
    logic [3:0] g_fl;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        g_en = {pc_en, if_id_en, id_ix_en,
                ix_im_en, im_iw_en};
        g_fl = {if_id_flush, id_ix_flush,
                ix_im_flush, im_iw_flush};
        n_cmp++;
        if ({g_en, g_fl, fwd_a_sel, fwd_b_sel}
            !== {e.en, e.fl, e.fa, e.fb}) begin
          n_bad++;
          $display("FAIL %s ctrl: got en=%b fl=%b fa=%b fb=%b want en=%b fl=%b fa=%b fb=%b",
                   e.nm, g_en, g_fl, fwd_a_sel, fwd_b_sel,
                   e.en, e.fl, e.fa, e.fb);
        end
        n_cmp++;
        if ({stall_cycles, flush_events, mem_err}
            !== {16'(e.st), 16'(e.fe), e.er}) begin
          n_bad++;
          $display("FAIL %s stats: got st=%0d fe=%0d err=%b want st=%0d fe=%0d err=%b",
                   e.nm, stall_cycles, flush_events, mem_err,
                   e.st, e.fe, e.er);
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    clr();
    im_write_to_reg = 1; im_dest_reg = 5'd3; ix_rs = 5'd3;
    @(posedge clk);
    #1;
    ex("rst1", 5'b01111, 4'b1111, 2'b00, 2'b00, 0, 0, 0);
    ex("rst2", 5'b01111, 4'b1111, 2'b00, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    clr();
    ex("run", 5'b11111, 4'b0000, 2'b00, 2'b00, 0, 0, 0);

    ix_is_load = 1; ix_write_to_reg = 1; ix_dest_reg = 5;
    id_rs = 5; id_uses_rs = 1;
    ex("lu_rs", 5'b00111, 4'b0100, 2'b00, 2'b00, 0, 0, 0);
    clr();
    im_write_to_reg = 1; im_dest_reg = 5; ix_rs = 5;
    ex("lu_fwd", 5'b11111, 4'b0000, 2'b01, 2'b00, 1, 0, 0);
    clr();
    ix_is_load = 1; ix_write_to_reg = 1; ix_dest_reg = 0;
    id_rs = 0; id_uses_rs = 1;
    ex("lu_r0", 5'b11111, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    clr();
    ix_is_load = 1; ix_write_to_reg = 1; ix_dest_reg = 5;
    id_rs = 5; id_uses_rs = 0; id_rt = 4; id_uses_rt = 1;
    ex("lu_nouse", 5'b11111, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
    ix_dest_reg = 4;
    ex("lu_rt", 5'b00111, 4'b0100, 2'b00, 2'b00, 1, 0, 0);

    clr();
    ix_update_pc = 1;
    ex("br", 5'b11111, 4'b1100, 2'b00, 2'b00, 2, 0, 0);
    ix_is_load = 1; ix_write_to_reg = 1; ix_dest_reg = 6;
    id_rt = 6; id_uses_rt = 1;
    ex("br_lu", 5'b11111, 4'b1100, 2'b00, 2'b00, 2, 1, 0);
    clr();
    ex("run2", 5'b11111, 4'b0000, 2'b00, 2'b00, 2, 2, 0);

    dmem_req = 1; dmem_ready = 0; ix_update_pc = 1;
    ex("wait1", 5'b00001, 4'b0001, 2'b00, 2'b00, 2, 2, 0);
    im_write_to_reg = 1; im_dest_reg = 9; ix_rs = 9;
    ex("wait2", 5'b00001, 4'b0001, 2'b01, 2'b00, 3, 2, 0);
    im_write_to_reg = 0; im_dest_reg = 0; ix_rs = 0;
    ex("wait3", 5'b00001, 4'b0001, 2'b00, 2'b00, 4, 2, 0);
    dmem_ready = 1;
    ex("wait_br", 5'b11111, 4'b1100, 2'b00, 2'b00, 5, 2, 0);
    clr();
    ex("run3", 5'b11111, 4'b0000, 2'b00, 2'b00, 5, 3, 0);

    dmem_req = 1; dmem_ready = 0;
    ex("tmo1", 5'b00001, 4'b0001, 2'b00, 2'b00, 5, 3, 0);
    ex("tmo2", 5'b00001, 4'b0001, 2'b00, 2'b00, 6, 3, 0);
    ex("tmo3", 5'b00001, 4'b0001, 2'b00, 2'b00, 7, 3, 0);
    ex("tmo4", 5'b00001, 4'b0001, 2'b00, 2'b00, 8, 3, 0);
    ex("tmo_adv", 5'b11111, 4'b0000, 2'b00, 2'b00, 9, 3, 0);
    clr();
    ex("tmo_err", 5'b11111, 4'b0000, 2'b00, 2'b00, 9, 3, 1);
    dmem_req = 1; dmem_ready = 0;
    ex("err_w", 5'b00001, 4'b0001, 2'b00, 2'b00, 9, 3, 1);
    dmem_ready = 1;
    ex("err_sticky", 5'b11111, 4'b0000, 2'b00, 2'b00, 10, 3, 1);

    clr();
    im_write_to_reg = 1; im_dest_reg = 7;
    iw_write_to_reg = 1; iw_dest_reg = 7;
    ix_rs = 7; ix_rt = 7;
    ex("fwd_im_iw", 5'b11111, 4'b0000, 2'b01, 2'b01, 10, 3, 1);
    im_dest_reg = 0; iw_dest_reg = 0;
    ix_rs = 0; ix_rt = 0;
    ex("fwd_r0", 5'b11111, 4'b0000, 2'b00, 2'b00, 10, 3, 1);
    im_write_to_reg = 0; im_dest_reg = 7; iw_dest_reg = 7;
    ix_rs = 3; ix_rt = 7;
    ex("fwd_iw", 5'b11111, 4'b0000, 2'b00, 2'b10, 10, 3, 1);
    im_write_to_reg = 1; im_dest_reg = 2;
    ix_rs = 2; ix_rt = 7;
    ex("fwd_split", 5'b11111, 4'b0000, 2'b01, 2'b10, 10, 3, 1);

    rst_n = 1'b0;
    clr();
    ex("rstA", 5'b01111, 4'b1111, 2'b00, 2'b00, 10, 3, 1);
    ex("rstB", 5'b01111, 4'b1111, 2'b00, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    ex("rstC", 5'b11111, 4'b0000, 2'b00, 2'b00, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: time limit hit, want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipeline (IF/ID/IX/IM/IW).
- Drives the enable and bubble-insert controls of the PC and of the IF/ID, ID/IX, IX/IM and IM/IW pipeline registers.
- Detects load-use hazards, taken branches resolved in IX, and multi-cycle data-memory waits in IM.
- Generates ALU operand forwarding selects for IX and keeps stall/flush statistics plus a sticky memory-timeout flag.

Parameters:
- MEM_TIMEOUT, 64: max consecutive MEM_WAIT cycles before abort; range 1..255.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; FSM/counters update on posedge; pipeline registers latch on negedge.
- rst_n  in  1  synchronous active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
- ix_rs, ix_rt  in  5 each  source registers of the instruction in IX.
- ix_dest_reg  in  5  destination of the instruction in IX.
- ix_write_to_reg, ix_is_load  in  1 each  IX writes a register / IX is a load.
- ix_update_pc  in  1  branch/jump taken, resolved in IX.
- im_dest_reg, iw_dest_reg  in  5 each  destinations in IM / IW.
- im_write_to_reg, iw_write_to_reg  in  1 each  register-write flags in IM / IW.
- dmem_req  in  1  IM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ix_en, ix_im_en, im_iw_en  out  1 each  stage advance enables.
- if_id_flush, id_ix_flush, ix_im_flush, im_iw_flush  out  1 each  load a bubble (all controls 0) instead of data.
- fwd_a_sel, fwd_b_sel  out  2 each  IX operand select: 00 regfile, 01 IM result, 10 IW result.
- stall_cycles, flush_events  out  CNT_W each  saturating statistics.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_n=0 sampled on posedge):
  - state=RUN; counters=0; mem_err=0; timeout counter=0.
  - While rst_n=0, outputs are forced combinationally: pc_en=0, all other enables=1, all flushes=1, fwd sels=00, so the unreset pipeline registers are cleared by the negedge latch.
- Output timing: enables, flushes and fwd sels are combinational from state and inputs and are stable before the negedge.
- States: RUN and MEM_WAIT.
- Memory wait (highest priority):
  - Condition: dmem_req=1 and dmem_ready=0, in either state.
  - Outputs: pc_en = if_id_en = id_ix_en = ix_im_en = 0; im_iw_en=1 with im_iw_flush=1, so IW receives a bubble and never writes twice.
  - Next state is MEM_WAIT; the timeout counter increments each wait cycle.
  - dmem_ready=1 returns to RUN and clears the timeout counter.
  - Timeout counter reaching MEM_TIMEOUT: set mem_err, force a one-cycle normal advance (the access is treated as complete), return to RUN.
- Taken branch (priority 2, RUN only, no memory wait):
  - ix_update_pc=1 gives pc_en=1 and all stage enables=1.
  - if_id_flush=1 and id_ix_flush=1 squash the two wrong-path instructions.
  - flush_events++.
  - A branch held in IX during MEM_WAIT is acted on in the cycle the wait ends.
- Load-use (priority 3):
  - Condition: ix_is_load & ix_write_to_reg & ix_dest_reg≠0 & ((id_uses_rs & id_rs==ix_dest_reg) | (id_uses_rt & id_rt==ix_dest_reg)).
  - Outputs: pc_en=0, if_id_en=0, id_ix_en=1 with id_ix_flush=1; IX, IM and IW advance.
  - Exactly one stall cycle, because the load then sits in IM and forwarding covers it.
  - A load-use coincident with a taken branch is ignored: the branch squashes the dependent instruction.
- Normal: all enables=1, all flushes=0.
- Forwarding, per operand, evaluated independently of stalls:
  - 01 if im_write_to_reg & im_dest_reg≠0 & im_dest_reg==src.
  - Else 10 if iw_write_to_reg & iw_dest_reg≠0 & iw_dest_reg==src.
  - Else 00. IM beats IW.
- stall_cycles increments on every cycle in which pc_en=0 with rst_n=1. Both counters saturate at all-ones.

Decomposition:
- Package pipeline_ctrl_pkg holds: state enum (RUN, MEM_WAIT), FWD_REG=2'b00 / FWD_IM=2'b01 / FWD_IW=2'b10, REG_ZERO=5'd0.
- Sub-module fwd_unit: purely combinational forwarding for one operand, instantiated twice. The FSM, hazard logic and counters stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> pc_en=0, all flushes=1, counters=0, mem_err=0; release -> all enables=1, flushes=0.
- Load-use: IX `lw $5` (ix_is_load=1, dest=5), ID id_rs=5 with id_uses_rs=1 -> one cycle of pc_en=0, if_id_en=0, id_ix_flush=1; next cycle fwd_a_sel=01; stall_cycles=1.
- Branch: ix_update_pc=1 -> if_id_flush=id_ix_flush=1 and pc_en=1 for one cycle; flush_events=1. Repeat with a simultaneous load-use match -> no stall.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> state MEM_WAIT for 3 cycles with upstream enables 0 and im_iw_flush=1; returns to RUN; stall_cycles=3.
- Timeout with MEM_TIMEOUT=4: dmem_ready held 0 -> mem_err=1 after 4 wait cycles, FSM returns to RUN; mem_err stays 1 until reset.
- Forwarding priority: im_dest=iw_dest=ix_rt=7, both writes=1 -> fwd_b_sel=01. With dest=0 -> fwd_b_sel=00.
